// File: rtl/ezp_pkg.sv
// Shared types and byte offsets for the EZPack packet decoder.
package ezp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        STREAM = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        ERR_NONE  = 3'd0,
        ERR_START = 3'd1,
        ERR_LEN   = 3'd2,
        ERR_END   = 3'd3,
        ERR_CHK   = 3'd4
    } err_code_e;

    // Fixed byte positions inside a packed packet.
    localparam int OFS_START = 0;
    localparam int OFS_CMD   = 1;
    localparam int OFS_LEN   = 2;
    localparam int OFS_PD    = 3;

endpackage

// File: rtl/ezp_pkt_check.sv
// Combinational EZPack packet validator: start, length, end and checksum.
// Positions that depend on LEN are only looked at once LEN is in range.
module ezp_pkt_check
    import ezp_pkg::*;
#(
    parameter logic [7:0] START_BYTE = 8'hAA,
    parameter logic [7:0] END_BYTE   = 8'h55,
    parameter int         MAX_PD_LEN = 2,
    parameter int         MAX_PKTLEN = MAX_PD_LEN + 5
) (
    input  logic [8*MAX_PKTLEN-1:0] pkt,
    output logic                    pass,
    output err_code_e               err_code
);

    logic [7:0] start_b;
    logic [7:0] cmd_b;
    logic [7:0] len_b;
    logic [7:0] chk_b;
    logic [7:0] end_b;
    logic [7:0] calc;
    logic       len_ok;

    assign start_b = pkt[8*OFS_START +: 8];
    assign cmd_b   = pkt[8*OFS_CMD +: 8];
    assign len_b   = pkt[8*OFS_LEN +: 8];

    // Pick CHK/END by constant-index mux and fold payload into the XOR sum.
    always_comb begin
        len_ok = (len_b != 8'd0) && (len_b <= 8'(MAX_PD_LEN));
        chk_b  = 8'd0;
        end_b  = 8'd0;
        calc   = cmd_b ^ len_b;
        for (int k = 1; k <= MAX_PD_LEN; k++) begin
            if (len_ok && (len_b == 8'(k))) begin
                chk_b = pkt[8*(OFS_PD+k) +: 8];
                end_b = pkt[8*(OFS_PD+k+1) +: 8];
            end
        end
        for (int k = 0; k < MAX_PD_LEN; k++) begin
            if (8'(k) < len_b) calc = calc ^ pkt[8*(OFS_PD+k) +: 8];
        end
    end

    // First failing check in priority order sets the code.
    always_comb begin
        err_code = ERR_NONE;
        if (start_b != START_BYTE)   err_code = ERR_START;
        else if (!len_ok)            err_code = ERR_LEN;
        else if (end_b != END_BYTE)  err_code = ERR_END;
        else if (chk_b != calc)      err_code = ERR_CHK;
        pass = (err_code == ERR_NONE);
    end

endmodule

// File: rtl/ezp_decode.sv
// EZPack packet decoder: accepts one packed packet, validates it in a
// single CHECK cycle, then streams the payload bytes with a last flag.
module ezp_decode
    import ezp_pkg::*;
#(
    parameter logic [7:0] START_BYTE = 8'hAA,
    parameter logic [7:0] END_BYTE   = 8'h55,
    parameter int         MAX_PD_LEN = 2,
    parameter int         MAX_PKTLEN = MAX_PD_LEN + 5,
    parameter int         CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [8*MAX_PKTLEN-1:0] i_data,
    input  logic                    i_valid,
    output logic                    i_ready,
    output logic [7:0]              o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic                    o_last,
    output logic [7:0]              o_cmd,
    output logic                    o_err,
    output logic [2:0]              o_err_code,
    output logic [CNT_W-1:0]        o_pkt_cnt,
    output logic [CNT_W-1:0]        o_err_cnt
);

    state_e                  state_q, state_d;
    logic [8*MAX_PKTLEN-1:0] pkt_q, pkt_d;
    logic [7:0]              idx_q, idx_d;
    logic [7:0]              cmd_q, cmd_d;
    err_code_e               err_code_q, err_code_d;
    logic [CNT_W-1:0]        pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;

    logic                    chk_pass;
    err_code_e               chk_code;
    logic [7:0]              len;
    logic [7:0]              pd_byte;
    logic                    last;

    ezp_pkt_check #(
        .START_BYTE (START_BYTE),
        .END_BYTE   (END_BYTE),
        .MAX_PD_LEN (MAX_PD_LEN),
        .MAX_PKTLEN (MAX_PKTLEN)
    ) u_check (
        .pkt      (pkt_q),
        .pass     (chk_pass),
        .err_code (chk_code)
    );

    assign len  = pkt_q[8*OFS_LEN +: 8];
    assign last = (idx_q == len - 8'd1);

    // Payload byte at the current stream index.
    always_comb begin
        pd_byte = 8'd0;
        for (int k = 0; k < MAX_PD_LEN; k++) begin
            if (idx_q == 8'(k)) pd_byte = pkt_q[8*(OFS_PD+k) +: 8];
        end
    end

    // Outputs decoded from registered state only.
    assign i_ready    = (state_q == IDLE);
    assign o_valid    = (state_q == STREAM);
    assign o_data     = o_valid ? pd_byte : 8'd0;
    assign o_last     = o_valid && last;
    assign o_cmd      = cmd_q;
    assign o_err      = (state_q == CHECK) && !chk_pass;
    assign o_err_code = o_err ? chk_code : err_code_q;
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_err_cnt  = err_cnt_q;

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        pkt_d      = pkt_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        err_code_d = err_code_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    pkt_d   = i_data;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (chk_pass) begin
                    cmd_d   = pkt_q[8*OFS_CMD +: 8];
                    idx_d   = 8'd0;
                    state_d = STREAM;
                end else begin
                    err_code_d = chk_code;
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (o_ready) begin
                    if (last) begin
                        if (pkt_cnt_q != '1) pkt_cnt_d = pkt_cnt_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pkt_q      <= '0;
            idx_q      <= 8'd0;
            cmd_q      <= 8'd0;
            err_code_q <= ERR_NONE;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pkt_q      <= pkt_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            err_code_q <= err_code_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

endmodule

// File: doc/ezp_decode.md
Name: ezp_decode

Overview:
- Sits directly downstream of the EZPack UART receive path and consumes one packed EZPack packet per valid/ready handshake.
- Validates start byte, length, checksum and end byte.
- Valid packets: emits the payload as a byte stream with a last flag and a latched command byte.
- Invalid packets: dropped, with an error pulse, an error code and a saturating error counter.

Parameters:
- START_BYTE, 8'hAA, expected byte 0.
- END_BYTE, 8'h55, expected terminator.
- MAX_PD_LEN, 2, maximum payload bytes.
- MAX_PKTLEN, MAX_PD_LEN+5, packet bytes in i_data.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_data  in  8*MAX_PKTLEN  packed packet; byte k is i_data[8k+7:8k].
- i_valid  in  1  packet valid.
- i_ready  out  1  block can accept a packet.
- o_data  out  8  payload byte.
- o_valid  out  1  payload byte valid.
- o_ready  in  1  downstream accepts byte.
- o_last  out  1  final payload byte of the packet.
- o_cmd  out  8  CMD byte of the current packet; held while streaming.
- o_err  out  1  one-cycle pulse on rejected packet.
- o_err_code  out  3  reason; valid while o_err=1.
- o_pkt_cnt  out  CNT_W  good packets completed; saturating.
- o_err_cnt  out  CNT_W  rejected packets; saturating.

Behaviour:
- Packet format: byte0 START, byte1 CMD, byte2 LEN, bytes 3..2+LEN payload, byte 3+LEN CHK, byte 4+LEN END. Bytes beyond 4+LEN are ignored.
- CHK is the XOR of CMD, LEN and all payload bytes.
- Reset (rst_n=0, asynchronous): state IDLE. All outputs 0 except i_ready=1 after reset release. Counters 0, internal packet register 0.
- FSM states: IDLE, CHECK, STREAM.
- IDLE:
  - i_ready=1, o_valid=0.
  - On i_valid&&i_ready: latch i_data into the packet register, go to CHECK.
- CHECK (exactly 1 cycle):
  - i_ready=0. Evaluate the error checks in priority order; the first failure sets the code:
    - 1 = START mismatch
    - 2 = LEN==0 or LEN>MAX_PD_LEN
    - 3 = END mismatch at byte 4+LEN
    - 4 = CHK mismatch
  - On failure: o_err=1 for this cycle, o_err_code=code, o_err_cnt+1 (saturating), next state IDLE.
  - On pass: latch o_cmd, idx=0, next state STREAM.
  - Bytes 3+LEN and 4+LEN are only indexed when the LEN check passes.
- STREAM:
  - o_valid=1, o_data=payload[idx], o_last=(idx==LEN-1), i_ready=0.
  - o_data and o_last are held stable while o_ready=0.
  - On o_valid&&o_ready with o_last=1: o_pkt_cnt+1 (saturating), next state IDLE.
  - On o_valid&&o_ready with o_last=0: idx+1.
- Latency: packet accepted at cycle T; first o_valid at T+2. i_ready returns high the cycle after the last byte handshake. Minimum packet period is LEN+2 cycles.
- o_err_code holds its last value after the pulse. o_cmd holds until the next good packet.
- Reset mid-STREAM drops the packet immediately; counters clear.
- All handshake outputs are registered or decoded from registered state only. No combinational path from i_valid or o_ready to i_ready.

Decomposition:
- ezp_pkg holds:
  - state enum {IDLE, CHECK, STREAM}
  - err code enum {ERR_NONE=0, ERR_START=1, ERR_LEN=2, ERR_END=3, ERR_CHK=4}
  - byte offset constants OFS_START=0, OFS_CMD=1, OFS_LEN=2, OFS_PD=3
- One combinational sub-module, ezp_pkt_check: takes the packet register and returns pass and err_code. It is reusable by a future TX-side self-check.

Test Plan:
- Good packet: bytes AA 01 02 11 22 30 55, o_ready=1.
  - Required: first o_valid two cycles after accept; o_data 11 then 22; o_last on 22; o_cmd=01; o_pkt_cnt=1; o_err never asserted.
- LEN=1 packet: AA 02 01 7E 7D 55 00.
  - Required: single byte 7E with o_last=1; trailing 00 ignored; o_pkt_cnt increments.
- Errors, one packet each:
  - Byte0=AB -> o_err=1, code 1.
  - LEN=03 -> code 2.
  - Good packet with byte6=54 -> code 3.
  - Good packet with CHK=31 -> code 4.
  - Required after all four: o_err_cnt=4, o_valid never asserted, i_ready high 2 cycles after each accept.
- Backpressure: good packet from the first scenario with o_ready low for 5 cycles on the first byte.
  - Required: o_data=11 held stable, i_ready=0 throughout, stream resumes in order.
- Back-to-back: i_valid held high with two good packets.
  - Required: second accepted the cycle after the first packet's last handshake; no byte lost or duplicated.
- Reset mid-stream: assert rst_n=0 after the first byte handshake of the first scenario.
  - Required: o_valid=0 and counters 0 immediately (asynchronous); the next packet decodes correctly.
